mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Sequencer and arbiter that shares one single-port unified memory between the Fetch-stage instruction port and the Memory-stage data port of the pipelined RV32I core. Data accesses win over fetches, and each access is handed to memory with a req/ack handshake. The block turns the decoder's StoreSrc/LoadSrc codes into byte enables, lane-replicated write data and sign/zero-extended load data. It also flags misaligned or illegal data accesses, and raises a sticky bus error when memory stops responding.

## Interface
- MAX_WAIT, 255: maximum cycles a granted access waits for mem_ack before a bus error (1..255).
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-high.
- if_req  in  1  fetch request; held with if_addr until if_ready.
- if_addr  in  32  fetch byte address (word aligned).
- if_rdata  out  32  instruction word; valid while if_ready.
- if_ready  out  1  one-cycle completion pulse for the fetch port.
- dm_req  in  1  data request; held with the other dm_* inputs until dm_ready.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  32  data byte address.
- dm_wdata  in  32  store data, right-aligned.
- dm_store_src  in  2  store width: 00 SW, 01 SH, 10 SB, 11 illegal.
- dm_load_src  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; all other codes illegal.
- dm_rdata  out  32  extended load data; valid while dm_ready.
- dm_ready  out  1  one-cycle completion pulse for the data port.
- dm_fault  out  1  high together with dm_ready when the access was misaligned or illegal.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  word address; bits [1:0] = 00.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated write data.
- mem_rdata  in  32  read data; valid while mem_ack.
- mem_ack  in  1  memory completion.
- bus_error  out  1  sticky timeout flag; cleared only by reset.

## Operation
- FSM states: IDLE, DATA, FETCH, FAULT, ERROR.
- IDLE, dm_req=1, access legal and aligned: register address, be, wdata, we, lane and load type; go to DATA.
- IDLE, dm_req=1, access misaligned or illegal: go to FAULT.
- IDLE, dm_req=0, if_req=1: register if_addr with be=1111, we=0; go to FETCH.
- IDLE, no request: stay in IDLE.
- Data has fixed priority. When both requests are present the same cycle, data goes first and fetch is served after the next IDLE.
- DATA/FETCH: mem_req=1 and outputs are driven from the registers.
  - mem_ack=1: pulse dm_ready or if_ready in the same cycle, read data taken combinationally from mem_rdata; next state IDLE.
  - mem_ack=0: wait counter increments; counter = MAX_WAIT → ERROR.
- FAULT: one cycle with dm_ready=1, dm_fault=1, dm_rdata=0, no memory access; then IDLE.
- ERROR: mem_req=0, no ready pulses, bus_error=1; leaves only on reset.
- Misaligned rules:
  - SW, LW: addr[1:0] must be 00.
  - SH, LH, LHU: addr[0] must be 0.
  - Byte accesses are never misaligned.
- Stores:
  - SB: be = 0001 shifted left by addr[1:0]; wdata = wdata[7:0] replicated ×4.
  - SH: be = 0011 shifted left by {addr[1],0}; wdata = wdata[15:0] replicated ×2.
  - SW: be = 1111.
- Loads: be = 1111. The registered lane selects the byte or half, then extend: LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- Reset (asynchronous, also mid-transaction):
  - State → IDLE and the wait counter clears.
  - Every output goes to 0 immediately, including mem_req, so a pending access is abandoned.
  - Requesters re-issue after reset.

## Timing
- Request → ready takes at least 1 cycle: request sampled in IDLE at cycle 0, mem_req at cycle 1, ready at cycle 1 if mem_ack is already high.
- Every memory access is followed by one IDLE cycle, so back-to-back accesses cost at least 2 cycles each.
- mem_* outputs are registered and stay stable while mem_req is high.
- Ready/rdata are combinational from mem_ack/mem_rdata.
- Stall relationships that the hazard unit derives: StallF = if_req & ~if_ready; StallM = dm_req & ~dm_ready.
- Timeout: mem_req high for MAX_WAIT consecutive cycles without mem_ack → ERROR on the next edge.

## Structure
- Package mem_pkg holds:
  - the state enum;
  - StoreSrc constants (SW/SH/SB);
  - LoadSrc constants (LB/LH/LW/LBU/LHU).
- Sub-module lsu_align is purely combinational: it generates be and wdata, checks misalignment/illegal codes, and extracts/extends load data.
- mem_arbiter holds the FSM, the request registers and the wait counter.

## Test plan
- SB, dm_addr=0x103, dm_wdata=0xAB, mem_ack on the first cycle → mem_addr=0x100, mem_be=1000, mem_wdata=0xABABABAB; dm_ready pulses 1 cycle after the request.
- LH, addr=0x202, mem_rdata=0x8001_0000 → dm_rdata=0xFFFF8001. Same access as LHU → dm_rdata=0x00008001.
- dm_req and if_req raised the same cycle, ack after 2 wait cycles each → data completes first, fetch's mem_req rises in the cycle after data's IDLE, if_ready follows.
- SW, addr=0x101 → mem_req stays 0; dm_ready=1 and dm_fault=1 for exactly 1 cycle.
- MAX_WAIT=4, mem_ack held 0 → bus_error=1 after 4 request cycles, mem_req drops, further requests are ignored until reset.
- Assert reset while in DATA with mem_req=1 → mem_req=0 with no clock edge; after release the FSM is in IDLE and a fresh LW completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and decoder codes for the unified-memory arbiter.
package mem_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DATA  = 3'd1,
    FETCH = 3'd2,
    FAULT = 3'd3,
    ERROR = 3'd4
  } state_t;

  // StoreSrc codes from the decoder (2'b11 is illegal)
  localparam logic [1:0] ST_SW = 2'b00;
  localparam logic [1:0] ST_SH = 2'b01;
  localparam logic [1:0] ST_SB = 2'b10;

  // LoadSrc codes from the decoder (unlisted codes are illegal)
  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, replicated store data,
// misalignment/illegal-code detection and load extraction/extension.
module lsu_align
  import mem_pkg::*;
(
  input  logic        we,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [1:0]  store_src,
  input  logic [2:0]  load_src,
  output logic [3:0]  be,
  output logic [31:0] lane_wdata,
  output logic        fault,
  input  logic [1:0]  lane,
  input  logic [2:0]  load_type,
  input  logic [31:0] raw_rdata,
  output logic [31:0] ext_rdata
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // request side: enables, lane-replicated data and fault detection
  always_comb begin
    be         = 4'b1111;
    lane_wdata = 32'd0;
    fault      = 1'b0;
    if (we) begin
      case (store_src)
        ST_SW: begin
          lane_wdata = wdata;
          fault      = (offset != 2'b00);
        end
        ST_SH: begin
          be         = 4'b0011 << {offset[1], 1'b0};
          lane_wdata = {2{wdata[15:0]}};
          fault      = offset[0];
        end
        ST_SB: begin
          be         = 4'b0001 << offset;
          lane_wdata = {4{wdata[7:0]}};
        end
        default: fault = 1'b1;
      endcase
    end else begin
      case (load_src)
        LD_LW:          fault = (offset != 2'b00);
        LD_LH, LD_LHU:  fault = offset[0];
        LD_LB, LD_LBU:  fault = 1'b0;
        default:        fault = 1'b1;
      endcase
    end
  end

  // response side: pick the addressed byte/half and extend it
  always_comb begin
    byte_sel  = 8'(raw_rdata >> {lane, 3'b000});
    half_sel  = lane[1] ? raw_rdata[31:16] : raw_rdata[15:0];
    ext_rdata = raw_rdata;
    case (load_type)
      LD_LB:   ext_rdata = 32'($signed(byte_sel));
      LD_LH:   ext_rdata = 32'($signed(half_sel));
      LD_LBU:  ext_rdata = {24'd0, byte_sel};
      LD_LHU:  ext_rdata = {16'd0, half_sel};
      default: ext_rdata = raw_rdata;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer sharing one single-port memory between the fetch
// port and the data port; data has fixed priority over fetch.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [1:0]  dm_store_src,
  input  logic [2:0]  dm_load_src,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic        dm_fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        bus_error
);

  state_t      state, state_next;
  logic [7:0]  wait_cnt;
  logic        timeout;

  logic [31:0] addr_p0;
  logic [31:0] wdata_p0;
  logic [3:0]  be_p0;
  logic        we_p0;
  logic [1:0]  lane_p0;
  logic [2:0]  ltype_p0;

  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        req_fault;
  logic [31:0] ext_rdata;
  logic        unused;

  // fetch addresses are word aligned; the low bits carry no information
  assign unused = ^if_addr[1:0];

  lsu_align u_align (
    .we         (dm_we),
    .offset     (dm_addr[1:0]),
    .wdata      (dm_wdata),
    .store_src  (dm_store_src),
    .load_src   (dm_load_src),
    .be         (req_be),
    .lane_wdata (req_wdata),
    .fault      (req_fault),
    .lane       (lane_p0),
    .load_type  (ltype_p0),
    .raw_rdata  (mem_rdata),
    .ext_rdata  (ext_rdata)
  );

  // counter holds cycles already spent waiting; last allowed cycle is MAX_WAIT-1
  assign timeout = (wait_cnt == 8'(MAX_WAIT - 1));

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // next-state: data before fetch, ERROR is absorbing until reset
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (dm_req)      state_next = req_fault ? FAULT : DATA;
        else if (if_req) state_next = FETCH;
      end
      DATA, FETCH: begin
        if (mem_ack)      state_next = IDLE;
        else if (timeout) state_next = ERROR;
      end
      FAULT:   state_next = IDLE;
      ERROR:   state_next = ERROR;
      default: state_next = IDLE;
    endcase
  end

  // wait counter runs only while an access is outstanding
  always_ff @(posedge clk or posedge reset) begin
    if (reset) wait_cnt <= 8'd0;
    else if ((state == DATA || state == FETCH) && !mem_ack) wait_cnt <= wait_cnt + 8'd1;
    else wait_cnt <= 8'd0;
  end

  // request capture in IDLE; held stable for the whole access
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_p0  <= 32'd0;
      wdata_p0 <= 32'd0;
      be_p0    <= 4'd0;
      we_p0    <= 1'b0;
      lane_p0  <= 2'd0;
      ltype_p0 <= 3'd0;
    end else if (state == IDLE) begin
      if (dm_req && !req_fault) begin
        addr_p0  <= {dm_addr[31:2], 2'b00};
        wdata_p0 <= req_wdata;
        be_p0    <= req_be;
        we_p0    <= dm_we;
        lane_p0  <= dm_addr[1:0];
        ltype_p0 <= dm_load_src;
      end else if (!dm_req && if_req) begin
        addr_p0  <= {if_addr[31:2], 2'b00};
        wdata_p0 <= 32'd0;
        be_p0    <= 4'b1111;
        we_p0    <= 1'b0;
      end
    end
  end

  assign mem_req   = (state == DATA) || (state == FETCH);
  assign mem_we    = we_p0;
  assign mem_addr  = addr_p0;
  assign mem_be    = be_p0;
  assign mem_wdata = wdata_p0;
  assign bus_error = (state == ERROR);

  // completion pulses and read data follow mem_ack combinationally
  always_comb begin
    dm_ready = 1'b0;
    dm_fault = 1'b0;
    dm_rdata = 32'd0;
    if_ready = 1'b0;
    if_rdata = 32'd0;
    case (state)
      DATA: if (mem_ack) begin
        dm_ready = 1'b1;
        dm_rdata = we_p0 ? 32'd0 : ext_rdata;
      end
      FETCH: if (mem_ack) begin
        if_ready = 1'b1;
        if_rdata = mem_rdata;
      end
      FAULT: begin
        dm_ready = 1'b1;
        dm_fault = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter with a rule-level model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = 32'd0;
  logic [31:0] dm_wdata = 32'd0;
  logic [1:0]  dm_store_src = 2'd0;
  logic [2:0]  dm_load_src = 3'd0;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        dm_fault;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ack = 1'b0;
  logic        bus_error;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;
  logic [31:0] last_rdata;

  mem_arbiter #(.MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_store_src(dm_store_src), .dm_load_src(dm_load_src),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready), .dm_fault(dm_fault),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: legality, enables, lane data and extended load value from the ISA rules
  task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [1:0] ss, input logic [2:0] ls, input logic [31:0] rd,
                       output logic ok, output logic [3:0] be,
                       output logic [31:0] ew, output logic [31:0] er);
    int off, b, h;
    off = int'(addr[1:0]);
    ok = 1'b1; be = 4'hF; ew = 32'd0; er = 32'd0;
    if (we) begin
      if (ss == 2'd3) ok = 1'b0;
      else if (ss == 2'd0) begin ok = (off == 0); ew = wd; end
      else if (ss == 2'd1) begin
        ok = (off % 2 == 0);
        be = 4'(3 << (off & 2));
        ew = (wd & 32'h0000FFFF) * 32'h00010001;
      end else begin
        be = 4'(1 << off);
        ew = (wd & 32'h000000FF) * 32'h01010101;
      end
    end else begin
      b = int'((rd >> (8 * off)) & 32'hFF);
      h = int'((rd >> (8 * (off & 2))) & 32'hFFFF);
      case (ls)
        3'd0: er = (b >= 128) ? 32'(b - 256) : 32'(b);
        3'd1: begin ok = (off % 2 == 0); er = (h >= 32768) ? 32'(h - 65536) : 32'(h); end
        3'd2: begin ok = (off == 0); er = rd; end
        3'd4: er = 32'(b);
        3'd5: begin ok = (off % 2 == 0); er = 32'(h); end
        default: ok = 1'b0;
      endcase
    end
  endtask

  // One data access starting in IDLE; memory answers after 'delay' wait cycles
  task automatic data_txn(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [1:0] ss, input logic [2:0] ls,
                          input int delay, input logic [31:0] rd);
    logic ok;
    logic [3:0] be;
    logic [31:0] ew, er;
    model(we, addr, wd, ss, ls, rd, ok, be, ew, er);
    dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wd;
    dm_store_src = ss; dm_load_src = ls;
    step();
    if (!ok) begin
      check({tag, "_fault_memreq"}, 32'(mem_req), 32'd0);
      check({tag, "_fault_ready"}, 32'(dm_ready), 32'd1);
      check({tag, "_fault_flag"}, 32'(dm_fault), 32'd1);
      check({tag, "_fault_rdata"}, dm_rdata, 32'd0);
      last_rdata = dm_rdata;
      step();
      dm_req = 1'b0;
      #1;
      check({tag, "_fault_ready_drop"}, 32'(dm_ready), 32'd0);
      check({tag, "_fault_flag_drop"}, 32'(dm_fault), 32'd0);
    end else begin
      for (int k = 0; k <= delay; k++) begin
        check({tag, "_memreq"}, 32'(mem_req), 32'd1);
        check({tag, "_memwe"}, 32'(mem_we), 32'(we));
        check({tag, "_memaddr"}, mem_addr, addr & 32'hFFFF_FFFC);
        check({tag, "_membe"}, 32'(mem_be), 32'(be));
        if (we) check({tag, "_memwdata"}, mem_wdata, ew);
        if (k == delay) begin
          mem_ack = 1'b1; mem_rdata = rd;
          #1;
          check({tag, "_ready"}, 32'(dm_ready), 32'd1);
          check({tag, "_nofault"}, 32'(dm_fault), 32'd0);
          if (!we) check({tag, "_rdata"}, dm_rdata, er);
          last_rdata = dm_rdata;
        end else begin
          mem_ack = 1'b0; mem_rdata = $urandom;
          #1;
          check({tag, "_wait_ready"}, 32'(dm_ready), 32'd0);
        end
        step();
      end
      mem_ack = 1'b0;
      dm_req = 1'b0;
      #1;
      check({tag, "_idle_memreq"}, 32'(mem_req), 32'd0);
      check({tag, "_idle_ready"}, 32'(dm_ready), 32'd0);
    end
  endtask

  // One fetch starting in IDLE
  task automatic fetch_txn(input string tag, input logic [31:0] addr, input int delay,
                           input logic [31:0] rd);
    if_req = 1'b1; if_addr = addr;
    step();
    for (int k = 0; k <= delay; k++) begin
      check({tag, "_memreq"}, 32'(mem_req), 32'd1);
      check({tag, "_memwe"}, 32'(mem_we), 32'd0);
      check({tag, "_memaddr"}, mem_addr, addr & 32'hFFFF_FFFC);
      check({tag, "_membe"}, 32'(mem_be), 32'hF);
      if (k == delay) begin
        mem_ack = 1'b1; mem_rdata = rd;
        #1;
        check({tag, "_ready"}, 32'(if_ready), 32'd1);
        check({tag, "_rdata"}, if_rdata, rd);
        check({tag, "_dm_quiet"}, 32'(dm_ready), 32'd0);
      end else begin
        mem_ack = 1'b0; mem_rdata = $urandom;
        #1;
        check({tag, "_wait_ready"}, 32'(if_ready), 32'd0);
      end
      step();
    end
    mem_ack = 1'b0;
    if_req = 1'b0;
    #1;
    check({tag, "_idle_memreq"}, 32'(mem_req), 32'd0);
    check({tag, "_idle_ready"}, 32'(if_ready), 32'd0);
  endtask

  initial begin
    // reset state
    step();
    step();
    check("rst_memreq", 32'(mem_req), 32'd0);
    check("rst_dmready", 32'(dm_ready), 32'd0);
    check("rst_ifready", 32'(if_ready), 32'd0);
    check("rst_buserr", 32'(bus_error), 32'd0);
    check("rst_memaddr", mem_addr, 32'd0);
    check("rst_membe", 32'(mem_be), 32'd0);
    reset = 1'b0;
    step();

    // SB to byte 3 with immediate ack
    data_txn("sb", 1'b1, 32'h103, 32'hAB, 2'b10, 3'd0, 0, 32'd0);
    // LH / LHU on upper half
    data_txn("lh", 1'b0, 32'h202, 32'd0, 2'b00, 3'b001, 0, 32'h8001_0000);
    check("lh_value", last_rdata, 32'hFFFF_8001);
    data_txn("lhu", 1'b0, 32'h202, 32'd0, 2'b00, 3'b101, 1, 32'h8001_0000);
    check("lhu_value", last_rdata, 32'h0000_8001);

    // simultaneous requests: data first, fetch after the following IDLE
    if_req = 1'b1; if_addr = 32'h400;
    data_txn("arb_data", 1'b0, 32'h300, 32'd0, 2'b00, 3'b010, 2, 32'h1234_5678);
    check("arb_data_value", last_rdata, 32'h1234_5678);
    check("arb_if_idle", 32'(if_ready), 32'd0);
    fetch_txn("arb_fetch", 32'h400, 2, 32'hCAFE_F00D);

    // misaligned SW
    data_txn("sw_mis", 1'b1, 32'h101, 32'h5555_AAAA, 2'b00, 3'd0, 0, 32'd0);

    // randomized data and fetch accesses
    for (int i = 0; i < 40; i++) begin
      data_txn("rnd_dm", 1'($urandom_range(0, 1)), $urandom, $urandom,
               2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
               int'($urandom_range(0, 3)), $urandom);
      if (i % 4 == 0)
        fetch_txn("rnd_if", $urandom & 32'hFFFF_FFFC, int'($urandom_range(0, 3)), $urandom);
    end

    // timeout with MAX_WAIT = 4
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h10; dm_load_src = 3'b010;
    mem_ack = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      check("to_memreq", 32'(mem_req), 32'd1);
      check("to_buserr_low", 32'(bus_error), 32'd0);
      step();
    end
    check("to_buserr", 32'(bus_error), 32'd1);
    check("to_memreq_drop", 32'(mem_req), 32'd0);
    dm_req = 1'b0; if_req = 1'b1; if_addr = 32'h80;
    for (int k = 0; k < 3; k++) begin
      step();
      check("err_memreq", 32'(mem_req), 32'd0);
      check("err_ifready", 32'(if_ready), 32'd0);
      check("err_sticky", 32'(bus_error), 32'd1);
    end
    if_req = 1'b0;
    reset = 1'b1;
    #1;
    check("err_clear", 32'(bus_error), 32'd0);
    step();
    reset = 1'b0;
    step();

    // asynchronous reset in the middle of a data access
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20; dm_load_src = 3'b010;
    step();
    check("mid_memreq", 32'(mem_req), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_memreq", 32'(mem_req), 32'd0);
    check("mid_rst_memaddr", mem_addr, 32'd0);
    check("mid_rst_dmready", 32'(dm_ready), 32'd0);
    dm_req = 1'b0;
    step();
    reset = 1'b0;
    step();
    data_txn("post_rst_lw", 1'b0, 32'h24, 32'd0, 2'b00, 3'b010, 1, 32'hDEAD_BEEF);
    check("post_rst_value", last_rdata, 32'hDEAD_BEEF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
